// File: rtl/pe_sat_mac.sv
// pe_sat_mac: systolic processing element with a saturating multiply-accumulate.
//
// Operands enter S1 and are forwarded to the neighbouring PE from there.
// S2 holds the full-width product and S3 holds the entry being accumulated.
// A dot product runs from a pair flagged first to a pair flagged last.
// Its saturated result appears on c_out, with c_valid pulsing for one
// advancing edge.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous active-low reset
//   en                  global advance; 0 holds every register
//   valid_in            a_in/b_in/first_in/last_in carry a real pair
//   a_in, b_in          operands (DATA_WIDTH)
//   first_in, last_in   dot-product delimiters
//   a_out, b_out        operands forwarded from S1
//   valid_out           valid forwarded from S1
//   first_out           first flag forwarded from S1
//   last_out            last flag forwarded from S1
//   c_out               completed, saturated dot product (ACC_WIDTH)
//   c_valid             c_out holds a new result
//   ovf                 saturation occurred in the dot product on c_out
module pe_sat_mac #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ACC_WIDTH   = 2 * DATA_WIDTH,
    parameter int unsigned SIGNED_MODE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  first_in,
    input  logic                  last_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  valid_out,
    output logic                  first_out,
    output logic                  last_out,
    output logic [ACC_WIDTH-1:0]  c_out,
    output logic                  c_valid,
    output logic                  ovf
);

    localparam int unsigned ProdWidth = 2 * DATA_WIDTH;
    localparam logic        IsSigned  = (SIGNED_MODE != 0);

    localparam logic [ACC_WIDTH-1:0] SignedMax   = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SignedMin   = {1'b1, {(ACC_WIDTH - 1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] UnsignedMax = {ACC_WIDTH{1'b1}};

    // ---------------------------------------------------------------- S1
    logic [DATA_WIDTH-1:0] s1_a_q, s1_b_q;
    logic                  s1_valid_q, s1_first_q, s1_last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else if (en) begin
            // Data is captured even for bubbles so the neighbour sees it.
            s1_a_q     <= a_in;
            s1_b_q     <= b_in;
            s1_valid_q <= valid_in;
            s1_first_q <= first_in;
            s1_last_q  <= last_in;
        end
    end

    assign a_out     = s1_a_q;
    assign b_out     = s1_b_q;
    assign valid_out = s1_valid_q;
    assign first_out = s1_first_q;
    assign last_out  = s1_last_q;

    // ---------------------------------------------------------------- S2
    // Extending both operands to the product width and keeping the low
    // ProdWidth bits yields the correct two's-complement product.
    logic [ProdWidth-1:0] op_a, op_b, prod_d;

    assign op_a   = {{DATA_WIDTH{IsSigned & s1_a_q[DATA_WIDTH-1]}}, s1_a_q};
    assign op_b   = {{DATA_WIDTH{IsSigned & s1_b_q[DATA_WIDTH-1]}}, s1_b_q};
    assign prod_d = op_a * op_b;

    logic [ProdWidth-1:0] s2_prod_q;
    logic                 s2_valid_q, s2_first_q, s2_last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_prod_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
        end else if (en) begin
            s2_prod_q  <= prod_d;
            s2_valid_q <= s1_valid_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
        end
    end

    // ---------------------------------------------------------------- S3
    // S3 holds the entry being accumulated, keeping the adder and
    // saturation logic off the multiplier path.
    logic [ProdWidth-1:0] s3_prod_q;
    logic                 s3_valid_q, s3_first_q, s3_last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_prod_q  <= '0;
            s3_valid_q <= 1'b0;
            s3_first_q <= 1'b0;
            s3_last_q  <= 1'b0;
        end else if (en) begin
            s3_prod_q  <= s2_prod_q;
            s3_valid_q <= s2_valid_q;
            s3_first_q <= s2_first_q;
            s3_last_q  <= s2_last_q;
        end
    end

    // Product extended to the accumulator width.
    logic [ACC_WIDTH-1:0] prod_ext;

    if (ACC_WIDTH > ProdWidth) begin : g_ext
        assign prod_ext = {{(ACC_WIDTH - ProdWidth){IsSigned & s3_prod_q[ProdWidth-1]}},
                           s3_prod_q};
    end else begin : g_noext
        assign prod_ext = s3_prod_q;
    end

    // ---------------------------------------------------------------- accumulate
    logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_base;
    logic                 sticky_q, sticky_d, sticky_base;
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf_now;
    logic [ACC_WIDTH-1:0] sat_val;
    logic [ACC_WIDTH-1:0] c_out_q, c_out_d;
    logic                 c_valid_q, c_valid_d;
    logic                 ovf_q, ovf_d;

    always_comb begin
        // A first entry starts from zero, so a single product never saturates.
        acc_base    = s3_first_q ? '0 : acc_q;
        sticky_base = s3_first_q ? 1'b0 : sticky_q;

        sum = {IsSigned & acc_base[ACC_WIDTH-1], acc_base}
            + {IsSigned & prod_ext[ACC_WIDTH-1], prod_ext};

        if (IsSigned) begin
            // Sign of the extra bit disagreeing with the MSB marks overflow.
            ovf_now = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
            sat_val = sum[ACC_WIDTH] ? SignedMin : SignedMax;
        end else begin
            ovf_now = sum[ACC_WIDTH];
            sat_val = UnsignedMax;
        end

        acc_d     = acc_q;
        sticky_d  = sticky_q;
        c_valid_d = 1'b0;
        c_out_d   = c_out_q;
        ovf_d     = ovf_q;

        if (s3_valid_q) begin
            acc_d    = ovf_now ? sat_val : sum[ACC_WIDTH-1:0];
            sticky_d = sticky_base | ovf_now;
            if (s3_last_q) begin
                c_valid_d = 1'b1;
                c_out_d   = acc_d;
                ovf_d     = sticky_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            c_out_q   <= '0;
            c_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (en) begin
            acc_q     <= acc_d;
            sticky_q  <= sticky_d;
            c_out_q   <= c_out_d;
            c_valid_q <= c_valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign c_out   = c_out_q;
    assign c_valid = c_valid_q;
    assign ovf     = ovf_q;

endmodule

// File: doc/pe_sat_mac.md
PE_SAT_MAC -- requirements
Module: pe_sat_mac

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of a/b operands.
REQ-002 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH: accumulator and c_out width; legal range is ACC_WIDTH >= 2*DATA_WIDTH.
REQ-003 SHALL have parameter SIGNED_MODE, default 1: 1 = two's-complement operands/accumulator, 0 = unsigned.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port en, input, 1 bit: global advance; 0 = every register holds.
REQ-007 SHALL have port valid_in, input, 1 bit: a_in/b_in/first_in/last_in carry a real operand pair.
REQ-008 SHALL have ports a_in and b_in, input, DATA_WIDTH each: operands.
REQ-009 SHALL have port first_in, input, 1 bit: this pair starts a new dot product.
REQ-010 SHALL have port last_in, input, 1 bit: this pair ends the dot product.
REQ-011 SHALL have ports a_out and b_out, output, DATA_WIDTH each: systolic forward of the operands.
REQ-012 SHALL have port valid_out, output, 1 bit: forward of valid_in, aligned with a_out/b_out.
REQ-013 SHALL have ports first_out and last_out, output, 1 bit each: forward of first_in/last_in, aligned with a_out/b_out.
REQ-014 SHALL have port c_out, output, ACC_WIDTH: completed, saturated dot-product result.
REQ-015 SHALL have port c_valid, output, 1 bit: c_out holds a new result.
REQ-016 SHALL have port ovf, output, 1 bit: saturation occurred during the dot product reported in c_out.

Function
REQ-017 SHALL use a 3-stage pipeline where every stage advances only on a clk edge with en=1.
- S1: register a, b, valid, first, last.
- S2: product = a*b, full 2*DATA_WIDTH, signed or unsigned per SIGNED_MODE.
- S3: accumulate.
REQ-018 SHALL drive a_out, b_out, valid_out, first_out and last_out directly from the S1 registers, giving 1-cycle forward latency.
REQ-019 SHALL forward operand data even when valid_in=0, with valid_out=0 in that case.
REQ-020 SHALL treat S2/S3 entries with valid=0 as bubbles: no change to the accumulator, ovf sticky, c_out or c_valid.
REQ-021 SHALL, on a valid S3 entry with first=1, load the accumulator with the sign- or zero-extended product (no add) and clear the ovf sticky before evaluating this entry.
REQ-022 SHALL, on a valid S3 entry with first=0, form accumulator + extended product at ACC_WIDTH+1 bits.
REQ-023 SHALL, on overflow in signed mode, clamp the accumulator to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) and set the ovf sticky.
REQ-024 SHALL, in unsigned mode, clamp the accumulator to 2^ACC_WIDTH-1 on overflow and set the ovf sticky.
REQ-025 SHALL keep the accumulator saturated across subsequent adds in the same dot product; it may leave saturation only by adding a product of opposite sign.
REQ-026 SHALL, on a valid S3 entry with last=1, load c_out with the new accumulator value and ovf with the updated sticky on the same edge, and set c_valid=1.
REQ-027 SHALL clear c_valid on the next en=1 edge that does not complete another last entry.
REQ-028 SHALL hold c_valid, c_out and ovf unchanged on en=0 edges.
REQ-029 SHALL produce c_valid 3 en=1 edges after the edge that samples the last pair.
REQ-030 SHALL, for first=1 and last=1 on the same pair, output that single product with ovf=0.
REQ-031 SHALL, for a valid pair with first=1 arriving while a previous dot product is unfinished, discard the unfinished sum without raising any error.
REQ-032 SHALL accept back-to-back dot products with no gap (last followed by first on the next cycle).
REQ-033 SHALL keep c_out at its old value until the new last completes.

Reset
REQ-034 SHALL, on rst=0, asynchronously clear all pipeline registers, the accumulator, the ovf sticky, a_out, b_out, valid_out, first_out, last_out, c_out, c_valid and ovf to 0, regardless of clk or en.
REQ-035 SHALL discard all in-flight entries when reset is asserted mid-operation.
REQ-036 SHALL, after rst returns to 1, require first=1 before results are meaningful; an accumulation starting without first adds to 0.

Verification
REQ-037 SHALL be verified for a basic dot product (DATA_WIDTH=8, SIGNED_MODE=1, en=1): pairs (3,4, first), (-2,5), (7,1, last) -> c_out=9, ovf=0, c_valid pulses 1 cycle, 3 edges after the last pair.
REQ-038 SHALL be verified for signed saturation (ACC_WIDTH=16): first (127,127) then 3x (127,127), last on the 4th -> c_out=32767, ovf=1.
REQ-039 SHALL be verified for the unsigned case (SIGNED_MODE=0): (255,255, first) then (255,255) then (2,1, last) -> c_out=65535, ovf=1.
REQ-040 SHALL be verified for stall: repeat the REQ-037 pairs with en=0 for 2 cycles between pairs and after the last -> same result; c_valid delayed by the stalls and held during en=0.
REQ-041 SHALL be verified for back-to-back operation with bubbles: (1,1, first+last), (2,2, first+last) on consecutive cycles, then valid_in=0 -> c_out=1 then 4 on consecutive cycles; a_out/b_out echo inputs 1 cycle later.
REQ-042 SHALL be verified for async reset: assert rst=0 mid-dot-product between clock edges -> all outputs 0 immediately; the next dot product after release is correct.
